id_scan: RTL and testbench
==========================

ID_SCAN -- requirements
Module: id_scan

Interface
REQ-001 SHALL have parameter LEN_W, default 8, width of token-length counter and tok_len.
REQ-002 SHALL have parameter CNT_W, default 16, width of match counter.
REQ-003 SHALL have parameter MIN_DIGITS, default 1, range 1..15, minimum trailing digit run for a match.
REQ-004 SHALL have parameter ALLOW_UNDERSCORE, default 0; when 1, '_' (0x5F) is classed as a letter.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  char is consumed on a rising edge when high.
REQ-008 char  input  8  ASCII character.
REQ-009 out  output  1  level: current token is letter-led and ends in >= MIN_DIGITS digits.
REQ-010 tok_done  output  1  one-cycle pulse: a token was just terminated.
REQ-011 tok_len  output  LEN_W  length of terminated token, valid while tok_done high.
REQ-012 tok_is_id  output  1  terminated token satisfied the out condition, valid while tok_done high.
REQ-013 match_cnt  output  CNT_W  number of terminated tokens with tok_is_id=1.

Function
REQ-014 Char classes SHALL be: LETTER = 0x41..0x5A, 0x61..0x7A (plus 0x5F if ALLOW_UNDERSCORE); DIGIT = 0x30..0x39; OTHER = everything else.
REQ-015 FSM SHALL have states IDLE, LET (in token, last char letter), DIG (in token, last char digit).
REQ-016 IDLE: LETTER -> LET; DIGIT or OTHER -> IDLE (leading digit does not start a token).
REQ-017 LET: LETTER -> LET; DIGIT -> DIG; OTHER -> IDLE.
REQ-018 DIG: LETTER -> LET; DIGIT -> DIG; OTHER -> IDLE.
REQ-019 Digit-run counter SHALL reset to 0 on LETTER, increment on DIGIT in LET/DIG, saturate at 15.
REQ-020 out SHALL be registered: out = (state==DIG) && (digit_run >= MIN_DIGITS); with MIN_DIGITS=1 this equals the legacy S2 output.
REQ-021 Token length SHALL load 1 on IDLE->LET, increment on each LETTER/DIGIT in LET/DIG, saturate at 2^LEN_W-1.
REQ-022 On OTHER consumed in LET or DIG, the next cycle SHALL show tok_done=1, tok_len=token length, tok_is_id=out value before the terminator.
REQ-023 tok_done SHALL be 0 in every other cycle; tok_len and tok_is_id SHALL hold last values when tok_done=0.
REQ-024 match_cnt SHALL increment in the same edge that raises tok_done with tok_is_id=1, saturating at 2^CNT_W-1.
REQ-025 in_valid=0 SHALL freeze state, counters and out; tok_done SHALL be 0 in the cycle following an idle edge.
REQ-026 Latency: all outputs reflect a consumed char exactly one edge later; no combinational path from char to any output.

Reset
REQ-027 reset=1 at a rising edge SHALL force state=IDLE, out=0, tok_done=0, tok_len=0, tok_is_id=0, match_cnt=0, internal counters=0.
REQ-028 reset SHALL dominate in_valid; a token in progress is discarded with no tok_done pulse.
REQ-029 Initial blocks SHALL NOT be relied on for functional reset.

Structure
REQ-030 Shared package id_scan_pkg SHALL hold state encoding (IDLE=2'b00, LET=2'b01, DIG=2'b10) and char-class codes/bounds.
REQ-031 Combinational sub-module char_class SHALL map char + ALLOW_UNDERSCORE to LETTER/DIGIT/OTHER.
REQ-032 Unused encoding 2'b11 SHALL transition to IDLE.

Verification
REQ-033 Defaults, stream "ab12 " -> out 0,0,1,1,0; tok_done after space with tok_len=4, tok_is_id=1, match_cnt=1.
REQ-034 Stream "9a1;" -> leading 9 ignored, tok_len=2, tok_is_id=1; stream "ab;" -> tok_done, tok_is_id=0, match_cnt unchanged.
REQ-035 MIN_DIGITS=3, "x12 x123 " -> first token tok_is_id=0, second tok_is_id=1, out high only after '3'.
REQ-036 ALLOW_UNDERSCORE=1, "_a1 " -> tok_len=3, tok_is_id=1; ALLOW_UNDERSCORE=0 same stream -> tok_len=2.
REQ-037 "ab1" with in_valid gaps between chars -> identical outputs to gapless run; reset asserted after '1' -> out=0, no tok_done, match_cnt=0.
REQ-038 LEN_W=3, 10-letter token then space -> tok_len=7 (saturated); CNT_W=2, 5 matching tokens -> match_cnt=3.

Source files
------------

// File: rtl/id_scan_pkg.sv
// Shared definitions for the identifier scanner: FSM state encoding,
// character-class codes and the ASCII bounds used for classification.
package id_scan_pkg;

  // FSM state encoding; 2'b11 is unused and recovers to IDLE.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LET  = 2'b01;
  localparam logic [1:0] ST_DIG  = 2'b10;

  // Character-class codes produced by char_class.
  localparam logic [1:0] CLS_OTHER  = 2'b00;
  localparam logic [1:0] CLS_LETTER = 2'b01;
  localparam logic [1:0] CLS_DIGIT  = 2'b10;

  // ASCII bounds.
  localparam logic [7:0] UPPER_LO   = 8'h41;
  localparam logic [7:0] UPPER_HI   = 8'h5A;
  localparam logic [7:0] LOWER_LO   = 8'h61;
  localparam logic [7:0] LOWER_HI   = 8'h7A;
  localparam logic [7:0] DIGIT_LO   = 8'h30;
  localparam logic [7:0] DIGIT_HI   = 8'h39;
  localparam logic [7:0] UNDERSCORE = 8'h5F;

  // Trailing digit-run counter saturates at 15.
  localparam int         RUN_W   = 4;
  localparam logic [3:0] RUN_MAX = 4'd15;

  // Inclusive range test on an ASCII code.
  function automatic logic in_range(input logic [7:0] c,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/id_scan_char_class.sv
// Purely combinational classifier: ASCII byte -> LETTER / DIGIT / OTHER.
module char_class
  import id_scan_pkg::*;
#(
  parameter int ALLOW_UNDERSCORE = 0
) (
  input  logic [7:0] char,
  output logic [1:0] cls
);

  // Digits first, then letters (optionally including '_'), everything else OTHER.
  always_comb begin
    cls = CLS_OTHER;
    if (in_range(char, DIGIT_LO, DIGIT_HI)) begin
      cls = CLS_DIGIT;
    end else if (in_range(char, UPPER_LO, UPPER_HI) ||
                 in_range(char, LOWER_LO, LOWER_HI) ||
                 ((ALLOW_UNDERSCORE != 0) && (char == UNDERSCORE))) begin
      cls = CLS_LETTER;
    end
  end

endmodule

// File: rtl/id_scan.sv
// Identifier scanner: tracks letter-led tokens in a character stream and
// flags those ending in a run of at least MIN_DIGITS digits.
//
// Input handshake: there is no ready; the DUT is always able to accept.
// A character is consumed on every rising edge where in_valid is high, and
// an edge with in_valid low leaves all state untouched. Every output is a
// register, so a consumed character is visible exactly one edge later.
module id_scan
  import id_scan_pkg::*;
#(
  parameter int LEN_W            = 8,
  parameter int CNT_W            = 16,
  parameter int MIN_DIGITS       = 1,
  parameter int ALLOW_UNDERSCORE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       char,
  output logic             out,
  output logic             tok_done,
  output logic [LEN_W-1:0] tok_len,
  output logic             tok_is_id,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       dbg_state
);

  localparam logic [RUN_W-1:0] MIN_RUN = RUN_W'(MIN_DIGITS);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       cls;
  logic [1:0]       state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             out_q, out_d;
  logic             tok_done_q, tok_done_d;
  logic [LEN_W-1:0] tok_len_q, tok_len_d;
  logic             tok_is_id_q, tok_is_id_d;
  logic [CNT_W-1:0] match_q, match_d;

  char_class #(
    .ALLOW_UNDERSCORE(ALLOW_UNDERSCORE)
  ) u_char_class (
    .char(char),
    .cls (cls)
  );

  // Next-state: FSM, digit run, token length, termination report and match count.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    len_d       = len_q;
    out_d       = out_q;
    tok_done_d  = 1'b0;
    tok_len_d   = tok_len_q;
    tok_is_id_d = tok_is_id_q;
    match_d     = match_q;
    if (in_valid) begin
      case (state_q)
        ST_IDLE: begin
          // A leading digit or punctuation never opens a token.
          if (cls == CLS_LETTER) begin
            state_d = ST_LET;
            run_d   = '0;
            len_d   = LEN_W'(1);
          end
        end
        ST_LET, ST_DIG: begin
          case (cls)
            CLS_LETTER: begin
              state_d = ST_LET;
              run_d   = '0;
              len_d   = (len_q == LEN_MAX) ? len_q : len_q + LEN_W'(1);
            end
            CLS_DIGIT: begin
              state_d = ST_DIG;
              run_d   = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
              len_d   = (len_q == LEN_MAX) ? len_q : len_q + LEN_W'(1);
            end
            default: begin
              // Terminator: report the token as it stood before this char.
              state_d     = ST_IDLE;
              tok_done_d  = 1'b1;
              tok_len_d   = len_q;
              tok_is_id_d = out_q;
              if (out_q && (match_q != CNT_MAX)) begin
                match_d = match_q + CNT_W'(1);
              end
            end
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
      out_d = (state_d == ST_DIG) && (run_d >= MIN_RUN);
    end
  end

  // State registers with synchronous reset; reset discards any open token.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      run_q       <= '0;
      len_q       <= '0;
      out_q       <= 1'b0;
      tok_done_q  <= 1'b0;
      tok_len_q   <= '0;
      tok_is_id_q <= 1'b0;
      match_q     <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      len_q       <= len_d;
      out_q       <= out_d;
      tok_done_q  <= tok_done_d;
      tok_len_q   <= tok_len_d;
      tok_is_id_q <= tok_is_id_d;
      match_q     <= match_d;
    end
  end

  assign out       = out_q;
  assign tok_done  = tok_done_q;
  assign tok_len   = tok_len_q;
  assign tok_is_id = tok_is_id_q;
  assign match_cnt = match_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_id_scan.sv
// Bench for id_scan: four parameterisations side by side, each with its own
// in_valid. Token reports are checked by a scoreboard fed by the tests.
module tb_id_scan;

  logic       clk;
  logic       reset;
  logic [3:0] vld;
  logic [7:0] ch;

  int n_checks;
  int n_fail;

  // Per-instance observation vectors (0=default, 1=MIN_DIGITS 3,
  // 2=ALLOW_UNDERSCORE 1, 3=LEN_W 3 / CNT_W 2).
  logic [3:0]  out_v;
  logic [3:0]  done_v;
  logic [24:0] act_v [4];
  logic [1:0]  st_v  [4];

  logic [24:0] exp_q [4][$];

  logic [7:0]  len0, len1, len2;
  logic [2:0]  len3;
  logic [3:0]  id_v;
  logic [15:0] m0, m1, m2;
  logic [1:0]  m3;

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  id_scan u_def (
    .clk(clk), .reset(reset), .in_valid(vld[0]), .char(ch),
    .out(out_v[0]), .tok_done(done_v[0]), .tok_len(len0),
    .tok_is_id(id_v[0]), .match_cnt(m0), .dbg_state(st_v[0])
  );

  id_scan #(.MIN_DIGITS(3)) u_md3 (
    .clk(clk), .reset(reset), .in_valid(vld[1]), .char(ch),
    .out(out_v[1]), .tok_done(done_v[1]), .tok_len(len1),
    .tok_is_id(id_v[1]), .match_cnt(m1), .dbg_state(st_v[1])
  );

  id_scan #(.ALLOW_UNDERSCORE(1)) u_us (
    .clk(clk), .reset(reset), .in_valid(vld[2]), .char(ch),
    .out(out_v[2]), .tok_done(done_v[2]), .tok_len(len2),
    .tok_is_id(id_v[2]), .match_cnt(m2), .dbg_state(st_v[2])
  );

  id_scan #(.LEN_W(3), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .in_valid(vld[3]), .char(ch),
    .out(out_v[3]), .tok_done(done_v[3]), .tok_len(len3),
    .tok_is_id(id_v[3]), .match_cnt(m3), .dbg_state(st_v[3])
  );

  assign act_v[0] = {len0, id_v[0], m0};
  assign act_v[1] = {len1, id_v[1], m1};
  assign act_v[2] = {len2, id_v[2], m2};
  assign act_v[3] = {5'b0, len3, id_v[3], 14'b0, m3};

  function automatic logic [24:0] tok(input int len, input bit id, input int m);
    return {8'(len), id, 16'(m)};
  endfunction

  // Scoreboard: every tok_done pulse must match the oldest expectation.
  always @(negedge clk) begin
    logic [24:0] e;
    for (int k = 0; k < 4; k++) begin
      if (done_v[k] === 1'b1) begin
        n_checks++;
        if (exp_q[k].size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_tok_done inst=%0d got=%h required=no_pulse", k, act_v[k]);
        end else begin
          e = exp_q[k].pop_front();
          if (act_v[k] !== e) begin
            n_fail++;
            $display("FAIL tok_report inst=%0d got=%h required=%h", k, act_v[k], e);
          end
        end
      end
    end
  end

  // Driver: consume one char on instance sel, sample #1 after the edge.
  task automatic step(input int sel, input logic [7:0] c);
    ch       = c;
    vld      = 4'b0;
    vld[sel] = 1'b1;
    @(posedge clk);
    #1;
    vld = 4'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a string and check out after each char (and each gap cycle).
  task automatic send_str(input int sel, input string s, input string exp_out,
                          input int gap);
    for (int i = 0; i < s.len(); i++) begin
      step(sel, s[i]);
      n_checks++;
      if (out_v[sel] !== (exp_out[i] == "1")) begin
        n_fail++;
        $display("FAIL out inst=%0d str=\"%s\" idx=%0d got=%b required=%c",
                 sel, s, i, out_v[sel], exp_out[i]);
      end
      for (int g = 0; g < gap; g++) begin
        idle(1);
        n_checks++;
        if (out_v[sel] !== (exp_out[i] == "1")) begin
          n_fail++;
          $display("FAIL out_gap inst=%0d idx=%0d got=%b required=%c",
                   sel, i, out_v[sel], exp_out[i]);
        end
      end
    end
  endtask

  task automatic drain_check(input int sel);
    idle(1);
    n_checks++;
    if (exp_q[sel].size() != 0) begin
      n_fail++;
      $display("FAIL missing_tok_done inst=%0d got=%0d_pending required=0",
               sel, exp_q[sel].size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vld   = 4'b0;
    ch    = 8'h00;
    idle(2);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({out_v[k], done_v[k], act_v[k], st_v[k]} !== 29'd0) begin
        n_fail++;
        $display("FAIL reset_state inst=%0d got=%b%b_%h_%b required=all_zero",
                 k, out_v[k], done_v[k], act_v[k], st_v[k]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    send_str(0, "ab12 ", "00110", 0);
    exp_q[0].push_back(tok(4, 1'b1, 1));
    drain_check(0);
  endtask

  task automatic test_leading_digit();
    send_str(0, "9a1;", "0010", 0);
    exp_q[0].push_back(tok(2, 1'b1, 2));
    send_str(0, "ab;", "000", 0);
    exp_q[0].push_back(tok(2, 1'b0, 2));
    drain_check(0);
    // Report fields hold once the pulse has gone.
    idle(2);
    n_checks++;
    if ({done_v[0], act_v[0]} !== {1'b0, tok(2, 1'b0, 2)}) begin
      n_fail++;
      $display("FAIL hold_after_done got=%b_%h required=0_%h",
               done_v[0], act_v[0], tok(2, 1'b0, 2));
    end
  endtask

  task automatic test_min_digits();
    send_str(1, "x12 ", "0000", 0);
    exp_q[1].push_back(tok(3, 1'b0, 0));
    send_str(1, "x123 ", "00010", 0);
    exp_q[1].push_back(tok(4, 1'b1, 1));
    drain_check(1);
  endtask

  task automatic test_underscore();
    send_str(2, "_a1 ", "0010", 0);
    exp_q[2].push_back(tok(3, 1'b1, 1));
    send_str(0, "_a1 ", "0010", 0);
    exp_q[0].push_back(tok(2, 1'b1, 3));
    drain_check(2);
    drain_check(0);
  endtask

  task automatic test_back_to_back();
    int match = 3;
    for (int t = 0; t < 8; t++) begin
      int n = $urandom_range(1, 4);
      int m = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        logic [7:0] c;
        c = ($urandom_range(0, 1) == 0) ? 8'(8'h61 + $urandom_range(0, 25))
                                        : 8'(8'h41 + $urandom_range(0, 25));
        step(0, c);
        n_checks++;
        if (out_v[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_out_letter tok=%0d got=%b required=0", t, out_v[0]);
        end
      end
      for (int j = 0; j < m; j++) begin
        step(0, 8'(8'h30 + $urandom_range(0, 9)));
        n_checks++;
        if (out_v[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL rnd_out_digit tok=%0d got=%b required=1", t, out_v[0]);
        end
      end
      if (m > 0) match++;
      step(0, ($urandom_range(0, 1) == 0) ? 8'h20 : 8'h2C);
      exp_q[0].push_back(tok(n + m, m > 0, match));
    end
    drain_check(0);
  endtask

  task automatic test_gaps_and_reset();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    send_str(0, "ab1", "001", 3);
    reset = 1'b1;
    vld   = 4'b0001;
    ch    = 8'h20;
    idle(1);
    vld   = 4'b0;
    n_checks++;
    if ({out_v[0], done_v[0], act_v[0]} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_mid_token got=%b%b_%h required=all_zero",
               out_v[0], done_v[0], act_v[0]);
    end
    reset = 1'b0;
    // Token was discarded, so a terminator now produces no pulse.
    send_str(0, " ", "0", 1);
    drain_check(0);
  endtask

  task automatic test_saturation();
    send_str(3, "abcdefghij ", "00000000000", 0);
    exp_q[3].push_back(tok(7, 1'b0, 0));
    for (int t = 1; t <= 5; t++) begin
      send_str(3, "a1 ", "010", 0);
      exp_q[3].push_back(tok(2, 1'b1, (t > 3) ? 3 : t));
    end
    drain_check(3);
    n_checks++;
    if (m3 !== 2'd3) begin
      n_fail++;
      $display("FAIL match_cnt_sat got=%0d required=3", m3);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    vld      = 4'b0;
    ch       = 8'h00;
    test_reset();
    test_basic();
    test_leading_digit();
    test_min_digits();
    test_underscore();
    test_back_to_back();
    test_gaps_and_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
